// File: rtl/pixel_readout_ctrl.sv
// rtl/pixel_readout_ctrl.sv - frame sequencer for a 4-pixel array on a shared DATA bus
module pixel_readout_ctrl #(
  parameter int ERASE_CYCLES  = 4,
  parameter int EXPOSE_CYCLES = 100,
  parameter int READ_SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       ERASE,
  output logic       EXPOSE,
  output logic       CONVERT,
  output logic       READ1,
  output logic       READ2,
  output logic       READ3,
  output logic       READ4,
  inout  wire  [7:0] DATA,
  output logic [7:0] pix_data,
  output logic [1:0] pix_idx,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_ERASE, S_EXPOSE, S_CONVERT, S_TURN, S_READ, S_OUT, S_DONE
  } state_t;

  state_t      state, next_state;
  logic [31:0] timer, next_timer;
  logic [7:0]  code, next_code;
  logic        drive;
  logic [1:0]  next_idx;
  logic [7:0]  next_pix_data;
  logic        n_busy, n_erase, n_expose, n_convert, n_valid, n_done, n_drive;
  logic [3:0]  n_read;

  // Outputs are registered from next-state decode so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= 32'd0;
      code       <= 8'd0;
      drive      <= 1'b0;
      pix_idx    <= 2'd0;
      pix_data   <= 8'd0;
      busy       <= 1'b0;
      ERASE      <= 1'b0;
      EXPOSE     <= 1'b0;
      CONVERT    <= 1'b0;
      READ1      <= 1'b0;
      READ2      <= 1'b0;
      READ3      <= 1'b0;
      READ4      <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= next_state;
      timer      <= next_timer;
      code       <= next_code;
      drive      <= n_drive;
      pix_idx    <= next_idx;
      pix_data   <= next_pix_data;
      busy       <= n_busy;
      ERASE      <= n_erase;
      EXPOSE     <= n_expose;
      CONVERT    <= n_convert;
      READ1      <= n_read[0];
      READ2      <= n_read[1];
      READ3      <= n_read[2];
      READ4      <= n_read[3];
      pix_valid  <= n_valid;
      frame_done <= n_done;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (start) next_state = S_ERASE;
      S_ERASE:   if (timer == 32'(ERASE_CYCLES - 1)) next_state = S_EXPOSE;
      S_EXPOSE:  if (timer == 32'(EXPOSE_CYCLES - 1)) next_state = S_CONVERT;
      S_CONVERT: if (code == 8'hFF) next_state = S_TURN;
      S_TURN:    next_state = S_READ;
      S_READ:    if (timer == 32'(READ_SETTLE - 1)) next_state = S_OUT;
      S_OUT:     if (pix_valid && pix_ready) next_state = (pix_idx == 2'd3) ? S_DONE : S_READ;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_comb begin
    next_timer    = (next_state == state && state != S_IDLE) ? timer + 32'd1 : 32'd0;
    next_code     = (state == S_CONVERT && next_state == S_CONVERT) ? code + 8'd1 : 8'd0;
    next_idx      = pix_idx;
    next_pix_data = pix_data;
    if (state == S_OUT && pix_valid && pix_ready)
      next_idx = (pix_idx == 2'd3) ? 2'd0 : pix_idx + 2'd1;
    // Capture on the last settle cycle; X/Z on the bus is passed through as-is.
    if (state == S_READ && timer == 32'(READ_SETTLE - 1))
      next_pix_data = DATA;
    n_busy    = (next_state != S_IDLE);
    n_erase   = (next_state == S_ERASE);
    n_expose  = (next_state == S_EXPOSE);
    n_convert = (next_state == S_CONVERT);
    n_drive   = (next_state == S_CONVERT);
    n_valid   = (next_state == S_OUT);
    n_done    = (next_state == S_DONE);
    n_read    = 4'b0000;
    if (next_state == S_READ)
      n_read[next_idx] = 1'b1;
  end

  assign DATA = drive ? code : 8'hzz;

endmodule
